ack_bus_client: RTL
===================

// Module: ack_bus_client
// PURPOSE
//  Requester end of the shared ACK bus: one instance per source (MEM/SHA/AES/CTRL).
//  Queues the owning module's completion events, drives req to the ACK-bus arbiter and
//  retires one pending event per grant. Checks each grant against the broadcast winner ID.
//  Sits between a datapath module's done strobe and ack_bus_top's req_*/ack_ready_to_* pins.
// PARAMETERS
//  SOURCE_ID       2'b00  fixed bus ID of this source (MEM=0, SHA=1, AES=2, CTRL=3)
//  PEND_DEPTH      4      max outstanding completion events (>=1)
//  TIMEOUT_CYCLES  255    watchdog limit in cycles (used only with ACK_CLIENT_TIMEOUT_EN)
// PORTS
//  clk               in   1   single clock, all state rising-edge
//  rst               in   1   asynchronous, active-high reset
//  done_pulse        in   1   1-cycle strobe: owning module finished one transaction
//  done_ready        out  1   high when pending_cnt < PEND_DEPTH
//  req               out  1   request to arbiter (req_<src>), registered
//  ack_ready         in   1   one-hot grant from arbiter (ack_ready_to_<src>)
//  winner_source_id  in   2   broadcast winner ID
//  ack_event         in   1   broadcast: an ACK was granted this cycle
//  acked_pulse       out  1   1-cycle strobe: one pending event retired
//  pending_cnt       out  CW  outstanding events, CW = $clog2(PEND_DEPTH+1)
//  overflow          out  1   sticky: done_pulse arrived while full (event dropped)
//  proto_err         out  1   sticky: grant inconsistent with broadcast
//  timeout           out  1   sticky: watchdog expired (0 when macro absent)
// BEHAVIOUR
//  Reset: state=IDLE, pending_cnt=0, req=0, acked_pulse=0, done_ready=1,
//   overflow=0, proto_err=0, timeout=0. Async assert clears mid-request; no grant retained.
//  grant = req & ack_ready & ack_event & (winner_source_id == SOURCE_ID).
//  FSM (registered):
//   IDLE     req=0. pending_cnt>0 (or done_pulse accepted this cycle) -> REQ.
//   REQ      req=1. grant -> COOLDOWN; else stay.
//   COOLDOWN req=0 for exactly 1 cycle (lets lower-priority IDs win the open-drain
//            arbitration). -> REQ if pending_cnt>0, else IDLE.
//  Latency: done_pulse at cycle N -> pending_cnt+1 and req=1 at N+1. Grant sampled at
//   edge E -> acked_pulse=1, req=0, pending_cnt-1 during cycle E+1.
//  Counter: inc on done_pulse & done_ready; dec on grant; both same cycle -> unchanged.
//   done_pulse while full and no same-cycle grant -> dropped, overflow set. Full with a
//   same-cycle grant -> accepted (net unchanged), no overflow. Never wraps.
//  proto_err set if ack_ready while req=0, or ack_ready & winner_source_id!=SOURCE_ID,
//   or ack_ready without ack_event. Such cycles do not count as grants.
//  Stickies clear only on rst.
// CONFIGURATION
//  ACK_CLIENT_TIMEOUT_EN defined: watchdog counts consecutive cycles in REQ without grant;
//   resets on grant or leaving REQ; reaching TIMEOUT_CYCLES sets timeout (req stays high,
//   counter saturates).
//  Undefined: no watchdog logic; timeout tied 0.
// STRUCTURE
//  ack_bus_pkg: ID_MEM/ID_SHA/ID_AES/ID_CTRL 2-bit constants, client FSM state encoding
//   (IDLE/REQ/COOLDOWN). Shared with ack_bus_top.
//  Sub-module ack_client_wdog (watchdog counter), instantiated only under
//   ACK_CLIENT_TIMEOUT_EN. Counter/FSM/error flags stay in this module.
// TESTING
//  1 Single: ID=1, done_pulse @c5, grant @c7 -> req 1 on c6-c7, acked_pulse @c8, cnt 1->0.
//  2 Burst: 3 done_pulses c2-c4, grant every REQ cycle -> req pattern 1,0,1,0,1;
//    3 acked_pulses; cnt ends 0.
//  3 Full: DEPTH=4, 5 done_pulses no grant -> cnt=4, done_ready=0, overflow=1;
//    5th with same-cycle grant -> cnt stays 4, overflow 0.
//  4 Contention: 4 clients on ack_bus_top, all pending 1 -> grants in ID order 0,1,2,3,
//    each acked once; no proto_err.
//  5 Error: ack_ready=1 with winner_source_id=2 to ID=1 client -> proto_err=1, cnt unchanged.
//  6 Reset/timeout: rst in REQ -> req=0, cnt=0 same cycle; with macro and
//    TIMEOUT_CYCLES=8, no grant 8 cycles -> timeout=1, req stays 1.

Source files
------------

// File: rtl/ack_bus_pkg.sv
// ---------------------------------------------------------------------------
// ack_bus_pkg
//   Shared definitions for the ACK bus: fixed 2-bit source IDs and the
//   requester-side (client) FSM state encoding. Used by ack_bus_client and
//   by ack_bus_top.
// ---------------------------------------------------------------------------
package ack_bus_pkg;

    // Fixed bus IDs. A lower ID wins the arbitration.
    localparam logic [1:0] ID_MEM  = 2'd0;
    localparam logic [1:0] ID_SHA  = 2'd1;
    localparam logic [1:0] ID_AES  = 2'd2;
    localparam logic [1:0] ID_CTRL = 2'd3;

    // Client FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,   // nothing pending, req low
        ST_REQ      = 2'd1,   // requesting, req high until granted
        ST_COOLDOWN = 2'd2    // one-cycle req-low gap after each grant
    } client_state_e;

endpackage : ack_bus_pkg

// File: rtl/ack_client_wdog.sv
// ---------------------------------------------------------------------------
// ack_client_wdog
//   Request watchdog for ack_bus_client. Counts consecutive cycles spent
//   requesting without a grant and raises a sticky timeout flag when the
//   count reaches TIMEOUT_CYCLES. The count restarts on a grant or whenever
//   the client is not requesting, and saturates at the limit.
//   Instantiated only when ACK_CLIENT_TIMEOUT_EN is defined.
//
// Ports
//   clk      in  1  clock, rising edge
//   rst      in  1  asynchronous active-high reset
//   in_req   in  1  client is in its requesting state this cycle
//   grant    in  1  client was granted this cycle
//   timeout  out 1  sticky: limit reached (cleared only by rst)
// ---------------------------------------------------------------------------
module ack_client_wdog #(
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int WW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_req,
    input  logic grant,
    output logic timeout
);

    localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT_CYCLES);

    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q,  timeout_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!in_req || grant) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
        timeout_d = timeout_q | (wait_cnt_d == LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule : ack_client_wdog

// File: rtl/ack_bus_client.sv
// ---------------------------------------------------------------------------
// ack_bus_client
//   Requester end of the shared ACK bus, one instance per source. Queues the
//   owning module's completion strobes in a saturating counter, requests the
//   bus while anything is pending and retires one event per grant. A grant
//   is only honoured when it is consistent with the broadcast winner ID;
//   anything else is flagged as a protocol error.
//
// Configuration
//   ACK_CLIENT_TIMEOUT_EN  when defined, a watchdog (ack_client_wdog) flags
//                          a request left ungranted for TIMEOUT_CYCLES;
//                          when undefined, timeout is tied low.
//
// Ports
//   clk               in   1   clock, rising edge
//   rst               in   1   asynchronous active-high reset
//   done_pulse        in   1   one-cycle strobe: one transaction completed
//   done_ready        out  1   counter not full
//   req               out  1   registered request to the arbiter
//   ack_ready         in   1   one-hot grant from the arbiter
//   winner_source_id  in   2   broadcast winner ID
//   ack_event         in   1   broadcast: a grant was issued this cycle
//   acked_pulse       out  1   one-cycle strobe: one pending event retired
//   pending_cnt       out  CW  outstanding events
//   overflow          out  1   sticky: completion dropped while full
//   proto_err         out  1   sticky: inconsistent grant seen
//   timeout           out  1   sticky: watchdog expired
// ---------------------------------------------------------------------------
module ack_bus_client
    import ack_bus_pkg::*;
#(
    parameter  logic [1:0] SOURCE_ID      = ID_MEM,
    parameter  int         PEND_DEPTH     = 4,
    parameter  int         TIMEOUT_CYCLES = 255,
    localparam int         CW             = $clog2(PEND_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done_pulse,
    output logic          done_ready,
    output logic          req,
    input  logic          ack_ready,
    input  logic [1:0]    winner_source_id,
    input  logic          ack_event,
    output logic          acked_pulse,
    output logic [CW-1:0] pending_cnt,
    output logic          overflow,
    output logic          proto_err,
    output logic          timeout
);

    if (PEND_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ack_bus_client: PEND_DEPTH and TIMEOUT_CYCLES must be >= 1");
    end

    localparam logic [CW-1:0] DEPTH_C = CW'(PEND_DEPTH);

    client_state_e state_q, state_d;
    logic [CW-1:0] pending_cnt_q, pending_cnt_d;
    logic          req_q,         req_d;
    logic          acked_pulse_q, acked_pulse_d;
    logic          overflow_q,    overflow_d;
    logic          proto_err_q,   proto_err_d;

    logic grant;
    logic full;
    logic accept;

    // ---------------------------------------------------------------------
    // Grant qualification, counter and sticky error flags
    // ---------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a value on every
    // path (default first), otherwise synthesis infers a latch.
    always_comb begin
        grant  = req_q & ack_ready & ack_event & (winner_source_id == SOURCE_ID);
        full   = (pending_cnt_q == DEPTH_C);
        // A full counter can still take a completion when a grant frees a
        // slot in the same cycle.
        accept = done_pulse & (~full | grant);

        pending_cnt_d = pending_cnt_q;
        unique case ({accept, grant})
            2'b10:   pending_cnt_d = pending_cnt_q + CW'(1);
            2'b01:   pending_cnt_d = pending_cnt_q - CW'(1);
            default: pending_cnt_d = pending_cnt_q;
        endcase

        overflow_d  = overflow_q  | (done_pulse & ~accept);
        // Any ack_ready that does not qualify as a grant is a protocol error.
        proto_err_d = proto_err_q | (ack_ready & ~grant);
    end

    // ---------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (pending_cnt_d != '0) state_d = ST_REQ;
            ST_REQ:      if (grant)               state_d = ST_COOLDOWN;
            // The one-cycle gap lets lower-priority IDs win arbitration.
            ST_COOLDOWN: state_d = (pending_cnt_d != '0) ? ST_REQ : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered: computed from the next state.
    always_comb begin
        req_d         = (state_d == ST_REQ);
        acked_pulse_d = grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_cnt_q <= '0;
            req_q         <= 1'b0;
            acked_pulse_q <= 1'b0;
            overflow_q    <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            pending_cnt_q <= pending_cnt_d;
            req_q         <= req_d;
            acked_pulse_q <= acked_pulse_d;
            overflow_q    <= overflow_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign done_ready  = ~full;
    assign req         = req_q;
    assign acked_pulse = acked_pulse_q;
    assign pending_cnt = pending_cnt_q;
    assign overflow    = overflow_q;
    assign proto_err   = proto_err_q;

    // ---------------------------------------------------------------------
    // Optional request watchdog
    // ---------------------------------------------------------------------
`ifdef ACK_CLIENT_TIMEOUT_EN
    ack_client_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .in_req  (state_q == ST_REQ),
        .grant   (grant),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

endmodule : ack_bus_client
